// File: rtl/sumador_serial.sv
// sumador_serial: bit-serial adder. Adds two ANCHO-bit operands one bit per
// clock, LSB first, using a single one-bit full adder and a registered carry.
// A start/done handshake sequences the operation.
//
// Ports:
//   Reloj          in   clock, rising edge
//   Reset_n        in   synchronous active-low reset
//   Inicio         in   start request, sampled only while idle
//   OperandoA      in   [ANCHO-1:0] first operand, captured on accept
//   OperandoB      in   [ANCHO-1:0] second operand, captured on accept
//   AcarreoEntrada in   carry-in, captured on accept
//   Ocupado        out  high while bits are being added
//   Listo          out  one-cycle pulse when the result becomes valid
//   Suma           out  [ANCHO-1:0] result of the last completed operation
//   AcarreoSalida  out  carry-out of the last completed operation

// One-bit full adder cell: the combinational building block of the datapath.
module SumadorCompleto (
  input  logic a,
  input  logic b,
  input  logic acarreo_entrada,
  output logic acarreo_salida,
  output logic suma
);
  assign suma           = a ^ b ^ acarreo_entrada;
  assign acarreo_salida = (a & b) | (acarreo_entrada & (a ^ b));
endmodule

module sumador_serial #(
  parameter int ANCHO = 8
) (
  input  logic             Reloj,
  input  logic             Reset_n,
  input  logic             Inicio,
  input  logic [ANCHO-1:0] OperandoA,
  input  logic [ANCHO-1:0] OperandoB,
  input  logic             AcarreoEntrada,
  output logic             Ocupado,
  output logic             Listo,
  output logic [ANCHO-1:0] Suma,
  output logic             AcarreoSalida
);

  localparam int CW = $clog2(ANCHO + 1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    SUMANDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t          estado;
  estado_t          siguiente;
  logic [ANCHO-1:0] reg_a;
  logic [ANCHO-1:0] reg_b;
  logic [ANCHO-1:0] resultado;
  logic             acarreo;
  logic [CW-1:0]    contador;
  logic             bit_suma;
  logic             bit_acarreo;
  logic             ultimo;

  SumadorCompleto u_celda (
    .a              (reg_a[0]),
    .b              (reg_b[0]),
    .acarreo_entrada(acarreo),
    .acarreo_salida (bit_acarreo),
    .suma           (bit_suma)
  );

  // The bit being added this cycle is the last one once the counter has
  // reached ANCHO-1; the edge that consumes it also moves to FIN.
  assign ultimo = (contador == CW'(ANCHO - 1));

  always_ff @(posedge Reloj) begin
    if (!Reset_n) begin
      estado <= REPOSO;
    end else begin
      estado <= siguiente;
    end
  end

  always_comb begin
    siguiente = estado;
    Ocupado   = 1'b0;
    Listo     = 1'b0;
    case (estado)
      REPOSO: begin
        if (Inicio) siguiente = SUMANDO;
      end
      SUMANDO: begin
        Ocupado = 1'b1;
        if (ultimo) siguiente = FIN;
      end
      FIN: begin
        Listo     = 1'b1;
        siguiente = REPOSO;
      end
      default: siguiente = REPOSO;
    endcase
  end

  // Datapath. Operands shift right so bit 0 always feeds the adder; sum bits
  // enter the result at the MSB so after ANCHO shifts the result is aligned.
  // The visible result is only updated on the final bit so it holds steady
  // through idle time and the whole of the next operation.
  always_ff @(posedge Reloj) begin
    if (!Reset_n) begin
      reg_a         <= '0;
      reg_b         <= '0;
      resultado     <= '0;
      acarreo       <= 1'b0;
      contador      <= '0;
      Suma          <= '0;
      AcarreoSalida <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (Inicio) begin
            reg_a    <= OperandoA;
            reg_b    <= OperandoB;
            acarreo  <= AcarreoEntrada;
            contador <= '0;
          end
        end
        SUMANDO: begin
          resultado <= {bit_suma, resultado[ANCHO-1:1]};
          reg_a     <= {1'b0, reg_a[ANCHO-1:1]};
          reg_b     <= {1'b0, reg_b[ANCHO-1:1]};
          acarreo   <= bit_acarreo;
          contador  <= contador + CW'(1);
          if (ultimo) begin
            Suma          <= {bit_suma, resultado[ANCHO-1:1]};
            AcarreoSalida <= bit_acarreo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial: an 8-bit instance driven from a
// table of directed vectors plus hand-written multi-cycle sequences, and a
// 2-bit instance for the narrowest legal width.
module tb_sumador_serial;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       inicio;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       cin;
  logic       ocupado;
  logic       listo;
  logic [7:0] suma;
  logic       cout;

  logic       inicio2;
  logic [1:0] op_a2;
  logic [1:0] op_b2;
  logic       cin2;
  logic       ocupado2;
  logic       listo2;
  logic [1:0] suma2;
  logic       cout2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sumador_serial #(.ANCHO(8)) dut8 (
    .Reloj(clk), .Reset_n(reset_n), .Inicio(inicio),
    .OperandoA(op_a), .OperandoB(op_b), .AcarreoEntrada(cin),
    .Ocupado(ocupado), .Listo(listo), .Suma(suma), .AcarreoSalida(cout)
  );

  sumador_serial #(.ANCHO(2)) dut2 (
    .Reloj(clk), .Reset_n(reset_n), .Inicio(inicio2),
    .OperandoA(op_a2), .OperandoB(op_b2), .AcarreoEntrada(cin2),
    .Ocupado(ocupado2), .Listo(listo2), .Suma(suma2), .AcarreoSalida(cout2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] exp_suma;
    logic       exp_cout;
  } vector_t;

  vector_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // One full operation on the 8-bit instance with Inicio pulsed for one cycle.
  task automatic applyStimulus(input vector_t v, input string tag);
    int n;
    int busy;
    op_a = v.a; op_b = v.b; cin = v.ci; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    op_a = 8'h00; op_b = 8'h00; cin = 1'b0;
    n = 0; busy = 0;
    while (!listo && n < 20) begin
      if (ocupado) busy++;
      tick();
      n++;
    end
    checkOutput({tag, " busy_cycles"}, busy, 8);
    checkOutput({tag, " latency_after_accept"}, n + 1, 9);
    checkOutput({tag, " suma"}, int'(suma), int'(v.exp_suma));
    checkOutput({tag, " cout"}, int'(cout), int'(v.exp_cout));
    tick();
    checkOutput({tag, " listo_one_cycle"}, int'(listo), 0);
    checkOutput({tag, " idle_after_fin"}, int'(ocupado), 0);
  endtask

  initial begin
    int pulses;
    int n;
    int accepts;
    int listo_cyc[3];
    int listo_sum[3];
    int listo_cout[3];
    logic prev_ocu;
    logic [7:0] seq_a[3];
    logic [7:0] seq_sum;
    logic       seq_cout;

    vecs[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    reset_n = 1'b0; inicio = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
    inicio2 = 1'b1; op_a2 = 2'd3; op_b2 = 2'd3; cin2 = 1'b1;
    tick(); tick();
    checkOutput("reset ocupado", int'(ocupado), 0);
    checkOutput("reset listo", int'(listo), 0);
    checkOutput("reset suma", int'(suma), 0);
    checkOutput("reset cout", int'(cout), 0);
    checkOutput("reset2 ocupado", int'(ocupado2), 0);
    checkOutput("reset2 suma", int'(suma2), 0);
    inicio = 1'b0; inicio2 = 1'b0;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Second request during SUMANDO must be ignored.
    op_a = 8'h10; op_b = 8'h20; cin = 1'b0; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick(); tick();
    checkOutput("ignore suma_held_midop", int'(suma), 8'h01);
    op_a = 8'h7F; op_b = 8'h7F; cin = 1'b1; inicio = 1'b1;
    tick();
    inicio = 1'b0; op_a = 8'hC3; op_b = 8'h3C;
    pulses = 0; seq_sum = 8'h00; seq_cout = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (listo) begin
        pulses++;
        seq_sum = suma;
        seq_cout = cout;
      end
      tick();
    end
    checkOutput("ignore listo_pulses", pulses, 1);
    checkOutput("ignore suma", int'(seq_sum), 8'h30);
    checkOutput("ignore cout", int'(seq_cout), 0);

    // Abort by reset mid-operation.
    applyStimulus('{8'h0A, 8'h0B, 1'b0, 8'h15, 1'b0}, "pre_abort");
    op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    tick(); tick(); tick();
    checkOutput("abort busy_before", int'(ocupado), 1);
    checkOutput("abort suma_before", int'(suma), 8'h15);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("abort ocupado", int'(ocupado), 0);
    checkOutput("abort listo", int'(listo), 0);
    checkOutput("abort suma", int'(suma), 0);
    checkOutput("abort cout", int'(cout), 0);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (listo || ocupado) pulses++;
      tick();
    end
    checkOutput("abort no_activity", pulses, 0);

    // Inicio held high: three back-to-back operations.
    seq_a[0] = 8'd1; seq_a[1] = 8'd2; seq_a[2] = 8'd3;
    op_a = seq_a[0]; op_b = 8'd1; cin = 1'b0; inicio = 1'b1;
    accepts = 0; pulses = 0; prev_ocu = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ocupado && !prev_ocu) begin
        accepts++;
        if (accepts < 3) op_a = seq_a[accepts];
        else inicio = 1'b0;
      end
      if (listo && pulses < 3) begin
        listo_cyc[pulses] = c;
        listo_sum[pulses] = int'(suma);
        listo_cout[pulses] = int'(cout);
        pulses++;
      end
      prev_ocu = ocupado;
    end
    checkOutput("b2b pulses", pulses, 3);
    if (pulses == 3) begin
      checkOutput("b2b first_latency", listo_cyc[0], 9);
      checkOutput("b2b gap01", listo_cyc[1] - listo_cyc[0], 10);
      checkOutput("b2b gap12", listo_cyc[2] - listo_cyc[1], 10);
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("b2b suma%0d", k), listo_sum[k], k + 2);
        checkOutput($sformatf("b2b cout%0d", k), listo_cout[k], 0);
      end
    end

    // Narrowest width: ANCHO=2, 3+3+1 = 7.
    op_a2 = 2'd3; op_b2 = 2'd3; cin2 = 1'b1; inicio2 = 1'b1;
    tick();
    inicio2 = 1'b0; op_a2 = 2'd0; op_b2 = 2'd0; cin2 = 1'b0;
    n = 0;
    while (!listo2 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("w2 latency_after_accept", n + 1, 3);
    checkOutput("w2 suma", int'(suma2), 3);
    checkOutput("w2 cout", int'(cout2), 1);
    tick();
    checkOutput("w2 listo_one_cycle", int'(listo2), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sumador_serial.md
# sumador_serial

Bit-serial adder that adds two ANCHO-bit operands one bit per clock, LSB first, using a single one-bit full adder and a registered carry. It sits directly downstream of the workshop's one-bit full adder: it consumes that adder's sum and carry each cycle and turns the purely combinational cell into a sequenced multi-bit datapath with a start/done handshake. It is the next lab step after the full-adder exercise, trading area for latency.

## Interface

- ANCHO, default 8, operand and result width in bits; legal range 2..32.

- Reloj  input  1  clock; all state changes on the rising edge.
- Reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of Reloj.
- Inicio  input  1  start request; sampled only in state REPOSO.
- OperandoA  input  ANCHO  first operand; captured when Inicio is accepted.
- OperandoB  input  ANCHO  second operand; captured when Inicio is accepted.
- AcarreoEntrada  input  1  carry-in; captured when Inicio is accepted.
- Ocupado  output  1  high while bits are being added (state SUMANDO).
- Listo  output  1  one-cycle pulse; result valid (state FIN).
- Suma  output  ANCHO  result of the last completed operation.
- AcarreoSalida  output  1  carry-out of the last completed operation.

## Operation

- Internal state: operand shift registers RegA and RegB (ANCHO bits each), carry flip-flop, result shift register, bit counter (width clog2(ANCHO+1)), 2-bit state register.
- Per-bit arithmetic: one instance of SumadorCompleto (port order A, B, carry-in, carry-out, sum) with inputs RegA[0], RegB[0] and the carry flip-flop.
- FSM states:
  - REPOSO: Ocupado=0, Listo=0. If Inicio=1: load RegA/RegB/carry from OperandoA/OperandoB/AcarreoEntrada, clear the counter, go to SUMANDO. Otherwise stay.
  - SUMANDO: Ocupado=1. Each cycle: shift the full-adder sum bit into the result register MSB (result shifts right), shift RegA and RegB right by one, load the carry flip-flop with the full-adder carry-out, increment the counter. When the counter reaches ANCHO-1 on this edge, go to FIN and load Suma from the completed result and AcarreoSalida from the final carry-out.
  - FIN: Listo=1 for exactly one cycle, then go unconditionally to REPOSO.
- Inicio is ignored in SUMANDO and FIN. No queueing of requests.
- Suma and AcarreoSalida change only on the transition into FIN (or on reset). They hold their value through REPOSO and the whole of the next operation.
- Operand inputs may change freely after the accept edge. Only the captured copies are used.
- Arithmetic: {AcarreoSalida, Suma} = OperandoA + OperandoB + AcarreoEntrada, exact in ANCHO+1 bits, no saturation.

## Timing

- Reset (Reset_n=0 at an edge) forces state REPOSO and clears every register. Outputs then read Ocupado=0, Listo=0, Suma=0, AcarreoSalida=0. Reset takes priority over Inicio.
- Reset asserted mid-operation aborts it: there is no Listo pulse and the previous Suma is lost (reads 0).
- Let edge 0 be the edge that samples Inicio=1 in REPOSO.
  - Ocupado is high after edges 0..ANCHO-1, i.e. for ANCHO cycles.
  - Listo is high after edge ANCHO, for one cycle.
  - Suma and AcarreoSalida are valid from edge ANCHO onward.
- Latency from the accept edge to Listo: ANCHO+1 edges. Minimum start-to-start period: ANCHO+2 cycles, because FIN is followed by at least one REPOSO cycle.
- Inicio held high continuously causes back-to-back operations. Each new operand set is captured at the first REPOSO edge after FIN.

## Test plan

- ANCHO=8, A=0x03, B=0x05, Cin=0, Inicio pulsed one cycle -> Ocupado high 8 cycles; Listo high exactly 1 cycle, 9 edges after accept; Suma=0x08, AcarreoSalida=0.
- A=0xFF, B=0x01, Cin=0 -> Suma=0x00, AcarreoSalida=1. Then A=0xFF, B=0xFF, Cin=1 -> Suma=0xFF, AcarreoSalida=1.
- Start A=0x10, B=0x20. Pulse Inicio again with A=0x7F, B=0x7F at cycle 3 of SUMANDO, and change the operand inputs -> second request ignored; result Suma=0x30, AcarreoSalida=0; only one Listo pulse.
- Complete A=0x0A, B=0x0B (Suma=0x15). Then start A=0xAA, B=0x55 and assert Reset_n=0 at SUMANDO cycle 4 -> next edge: Ocupado=0, Listo=0, Suma=0x00, AcarreoSalida=0; no Listo pulse follows.
- Inicio held high across 3 operations with A=1,2,3 and B=1,1,1 -> Listo pulses exactly 10 cycles apart; Suma=0x02, 0x03, 0x04 respectively.
- ANCHO=2 instance, A=3, B=3, Cin=1 -> Listo 3 edges after accept; Suma=3, AcarreoSalida=1.
